// File: rtl/mdu_pkg.sv
// Shared op-codes and helpers for the multiply/divide unit.
// FSM state encodings stay private to mdu.
package mdu_pkg;

  localparam int MDOP_W = 3;
  localparam int DATA_W = 32;

  typedef enum logic [MDOP_W-1:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  // Magnitude of a two's complement value; passes raw bits for unsigned ops.
  function automatic logic [DATA_W-1:0] abs_if(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Restoring radix-2 divider core: one quotient bit per cycle on a combined
// remainder/quotient shift register. Operands are unsigned magnitudes.
module div_iter
  import mdu_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              done
);

  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;

  logic [2*DATA_W-1:0] rq;
  logic [2*DATA_W-1:0] rq_nxt;
  logic [DATA_W-1:0]   dvs;
  logic [CNT_W-1:0]    cnt;
  logic                busy;
  logic [DATA_W+1:0]   diff;
  logic                ge;

  // Shifted partial remainder needs 33 bits; the extra sign bit decides restore.
  always_comb begin
    diff   = {1'b0, rq[2*DATA_W-1:DATA_W-1]} - {2'b00, dvs};
    ge     = ~diff[DATA_W+1];
    rq_nxt = ge ? {diff[DATA_W-1:0], rq[DATA_W-2:0], 1'b1}
                : {rq[2*DATA_W-2:0], 1'b0};
  end

  assign done      = busy && (cnt == CNT_W'(DIV_CYCLES - 1));
  assign quotient  = rq[DATA_W-1:0];
  assign remainder = rq[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq   <= '0;
      dvs  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (flush) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rq   <= {{DATA_W{1'b0}}, dividend};
      dvs  <= divisor;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      rq  <= rq_nxt;
      cnt <= done ? '0 : cnt + CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu.sv
// Execute-stage multiply/divide unit: 2-cycle multiply, 32-step divide,
// zero-latency MTHI/MTLO pass-through, stall request while busy.
module mdu
  import mdu_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdu_flush_i,
  input  logic        mdu_stall_i,
  input  logic        mdu_valid_i,
  input  logic [2:0]  mdu_op_i,
  input  logic [31:0] mdu_a_i,
  input  logic [31:0] mdu_b_i,
  output logic [31:0] mdu_hi_o,
  output logic [31:0] mdu_lo_o,
  output logic        mdu_whien_o,
  output logic        mdu_wloen_o,
  output logic        mdu_stallreq_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e      state;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        q_neg;
  logic        r_neg;

  logic        is_mul;
  logic        is_div;
  logic        sgn_div;
  logic        b_zero;
  logic        div_start;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic        mt_hi;
  logic        mt_lo;
  logic        done_en;

  assign is_mul  = (mdu_op_i == MD_MULT) || (mdu_op_i == MD_MULTU);
  assign is_div  = (mdu_op_i == MD_DIV)  || (mdu_op_i == MD_DIVU);
  assign sgn_div = (mdu_op_i == MD_DIV);
  assign b_zero  = (mdu_b_i == '0);

  assign div_start = (state == S_IDLE) && mdu_valid_i && is_div && !b_zero && !mdu_flush_i;

  div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (mdu_flush_i),
    .start     (div_start),
    .dividend  (abs_if(mdu_a_i, sgn_div)),
    .divisor   (abs_if(mdu_b_i, sgn_div)),
    .quotient  (div_q),
    .remainder (div_r),
    .done      (div_done)
  );

  // Operands are held by the stall, so the product is formed from live inputs in MUL.
  always_comb begin
    ext_a = {{32{(mdu_op_i == MD_MULT) & mdu_a_i[31]}}, mdu_a_i};
    ext_b = {{32{(mdu_op_i == MD_MULT) & mdu_b_i[31]}}, mdu_b_i};
    prod  = ext_a * ext_b;
    q_fix = q_neg ? (~div_q + 1'b1) : div_q;
    r_fix = r_neg ? (~div_r + 1'b1) : div_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      res_hi <= '0;
      res_lo <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
    end else if (mdu_flush_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (mdu_valid_i && is_mul) begin
            state <= S_MUL;
          end else if (mdu_valid_i && is_div) begin
            if (b_zero) begin
              res_hi <= mdu_a_i;
              res_lo <= '1;
              state  <= S_DONE;
            end else begin
              q_neg <= sgn_div & (mdu_a_i[31] ^ mdu_b_i[31]);
              r_neg <= sgn_div & mdu_a_i[31];
              state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          res_hi <= prod[63:32];
          res_lo <= prod[31:0];
          state  <= S_DONE;
        end
        S_DIV: if (div_done) state <= S_FIX;
        S_FIX: begin
          res_hi <= r_fix;
          res_lo <= q_fix;
          state  <= S_DONE;
        end
        S_DONE: if (!mdu_stall_i) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held, even if the pipeline still presents an op.
  assign mt_hi   = rst_n && !mdu_flush_i && (state == S_IDLE) && mdu_valid_i && (mdu_op_i == MD_MTHI);
  assign mt_lo   = rst_n && !mdu_flush_i && (state == S_IDLE) && mdu_valid_i && (mdu_op_i == MD_MTLO);
  assign done_en = rst_n && !mdu_flush_i && (state == S_DONE);

  assign mdu_hi_o       = !rst_n ? '0 : (mt_hi ? mdu_a_i : res_hi);
  assign mdu_lo_o       = !rst_n ? '0 : (mt_lo ? mdu_a_i : res_lo);
  assign mdu_whien_o    = done_en | mt_hi;
  assign mdu_wloen_o    = done_en | mt_lo;
  assign mdu_stallreq_o = rst_n && mdu_valid_i && (is_mul || is_div)
                          && (state != S_DONE) && !mdu_flush_i;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases plus random ops against
// an arithmetic reference model.
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, stall, valid;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        whien, wloen, stallreq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu #(.DIV_CYCLES(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mdu_flush_i    (flush),
    .mdu_stall_i    (stall),
    .mdu_valid_i    (valid),
    .mdu_op_i       (op),
    .mdu_a_i        (a),
    .mdu_b_i        (b),
    .mdu_hi_o       (hi),
    .mdu_lo_o       (lo),
    .mdu_whien_o    (whien),
    .mdu_wloen_o    (wloen),
    .mdu_stallreq_o (stallreq)
  );

  // Reference: results from plain integer arithmetic, latency from the timing table.
  function automatic void model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                output logic [31:0] eh, output logic [31:0] el, output int lat);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    eh = '0; el = '0; lat = 0;
    case (mop)
      3'd1: begin sp = longint'($signed(ma)) * longint'($signed(mb));
                  eh = sp[63:32]; el = sp[31:0]; lat = 2; end
      3'd2: begin up = longint'(ma) * longint'(mb);
                  eh = up[63:32]; el = up[31:0]; lat = 2; end
      3'd3, 3'd4: begin
        if (mb == 0) begin eh = ma; el = 32'hFFFF_FFFF; lat = 1; end
        else begin
          lat = 34;
          if (mop == 3'd4) begin el = ma / mb; eh = ma % mb; end
          else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin el = 32'h8000_0000; eh = 0; end
          else begin sa = ma; sb = mb; el = sa / sb; eh = sa % sb; end
        end
      end
      3'd5: eh = ma;
      3'd6: el = ma;
      default: lat = 0;
    endcase
  endfunction

  // Issues one op in the cycle after the current edge and follows it to completion.
  task automatic run_op(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb, input string tag);
    logic [31:0] eh, el;
    int lat, n;
    model(mop, ma, mb, eh, el, lat);
    @(posedge clk); #1;
    valid = 1'b1; op = mop; a = ma; b = mb;
    #1;
    if (lat == 0) begin
      checks++;
      if (whien !== (mop == 3'd5) || wloen !== (mop == 3'd6) || stallreq !== 1'b0) begin
        errors++;
        $display("FAIL %s mt_ctl: got we=%b%b sr=%b exp we=%b%b sr=0", tag, whien, wloen, stallreq, mop == 3'd5, mop == 3'd6);
      end
      checks++;
      if ((mop == 3'd5 && hi !== eh) || (mop == 3'd6 && lo !== el)) begin
        errors++;
        $display("FAIL %s mt_data: got hi=%h lo=%h exp hi=%h lo=%h", tag, hi, lo, eh, el);
      end
      return;
    end
    n = 0;
    while (whien !== 1'b1 && n < 60) begin
      checks++;
      if (stallreq !== 1'b1 || wloen !== 1'b0) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got sr=%b wlo=%b exp sr=1 wlo=0", tag, n, stallreq, wloen);
      end
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d exp %0d", tag, n, lat);
    end
    checks++;
    if (hi !== eh || lo !== el || whien !== 1'b1 || wloen !== 1'b1 || stallreq !== 1'b0) begin
      errors++;
      $display("FAIL %s result: got hi=%h lo=%h we=%b%b sr=%b exp hi=%h lo=%h we=11 sr=0",
               tag, hi, lo, whien, wloen, stallreq, eh, el);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    valid = 1'b0; op = 3'd0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 0; stall = 0; valid = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF; b = 0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (hi !== 0 || lo !== 0 || whien !== 0 || wloen !== 0 || stallreq !== 0) begin
      errors++;
      $display("FAIL reset_outputs: got hi=%h lo=%h we=%b%b sr=%b exp all 0", hi, lo, whien, wloen, stallreq);
    end
    valid = 1'b0; op = 3'd0;
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_directed();
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(3'd4, 32'hFFFF_FFFF, 32'h10, "divu_big");
    run_op(3'd3, 32'd5, 32'd0, "div_by_zero");
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd5, 32'h1234_5678, 32'd0, "mthi");
    run_op(3'd6, 32'h9ABC_DEF0, 32'd0, "mtlo");
    go_idle();
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    valid = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd7;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    #1;
    checks++;
    if (stallreq !== 0 || whien !== 0 || wloen !== 0) begin
      errors++;
      $display("FAIL flush_cycle: got sr=%b we=%b%b exp 0 00", stallreq, whien, wloen);
    end
    @(posedge clk); #1;
    flush = 1'b0; valid = 1'b0; op = 3'd0;
    #1;
    checks++;
    if (stallreq !== 0 || whien !== 0 || wloen !== 0) begin
      errors++;
      $display("FAIL after_flush: got sr=%b we=%b%b exp 0 00", stallreq, whien, wloen);
    end
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, "multu_after_flush");
    go_idle();
  endtask

  task automatic test_stall_done();
    logic [31:0] eh, el;
    int lat;
    model(3'd1, 32'h0001_2345, 32'hFFFF_0F00, eh, el, lat);
    run_op(3'd1, 32'h0001_2345, 32'hFFFF_0F00, "mult_stall");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      if (i == 2) stall = 1'b0;
      checks++;
      if (hi !== eh || lo !== el || whien !== 1 || wloen !== 1 || stallreq !== 0) begin
        errors++;
        $display("FAIL stall_hold %0d: got hi=%h lo=%h we=%b%b sr=%b exp hi=%h lo=%h we=11 sr=0",
                 i, hi, lo, whien, wloen, stallreq, eh, el);
      end
    end
    @(posedge clk); #1;
    valid = 1'b0; op = 3'd0;
    #1;
    checks++;
    if (whien !== 0 || wloen !== 0) begin
      errors++;
      $display("FAIL stall_release: got we=%b%b exp 00", whien, wloen);
    end
  endtask

  task automatic test_back_to_back();
    run_op(3'd3, 32'hFFFF_8000, 32'd3, "b2b_div0");
    run_op(3'd4, 32'hCAFE_F00D, 32'h0000_0123, "b2b_div1");
    run_op(3'd3, 32'd100, 32'hFFFF_FFF6, "b2b_div2");
    go_idle();
  endtask

  task automatic test_reset_mid_div();
    @(posedge clk); #1;
    valid = 1'b1; op = 3'd3; a = 32'd12345; b = 32'd17;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (hi !== 0 || lo !== 0 || whien !== 0 || wloen !== 0 || stallreq !== 0) begin
      errors++;
      $display("FAIL reset_mid_div: got hi=%h lo=%h we=%b%b sr=%b exp all 0", hi, lo, whien, wloen, stallreq);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; valid = 1'b0; op = 3'd0;
    run_op(3'd4, 32'd77, 32'd8, "div_after_reset");
    go_idle();
  endtask

  task automatic test_random();
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(1, 6));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_stall_done();
    test_back_to_back();
    test_reset_mid_div();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the execute stage. It computes MULT/MULTU/DIV/DIVU results and passes MTHI/MTLO operands through. Its hi/lo result and write enables travel down the pipeline to the writeback stage, which forwards them to the HILO register pair. Multi-cycle operations hold the pipeline through a stall request to the controller.

## Interface
Parameters:
- `DIV_CYCLES`, 32: number of divider iterations. Fixed at 32 for 32-bit operands.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mdu_flush_i`  in  1  pipeline flush from the controller; abandons any operation in progress.
- `mdu_stall_i`  in  1  downstream stall from the controller; the execute stage is being held.
- `mdu_valid_i`  in  1  a valid instruction sits in execute. It stays held while `mdu_stallreq_o` is high.
- `mdu_op_i`  in  3  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
- `mdu_a_i`  in  32  rs operand (dividend, multiplicand, or MTHI/MTLO source).
- `mdu_b_i`  in  32  rt operand (divisor, multiplier).
- `mdu_hi_o`  out  32  hi result.
- `mdu_lo_o`  out  32  lo result.
- `mdu_whien_o`  out  1  hi write enable.
- `mdu_wloen_o`  out  1  lo write enable.
- `mdu_stallreq_o`  out  1  stall request to the controller.

## Operation
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- **IDLE**
  - valid with MULT/MULTU → MUL.
  - valid with DIV/DIVU and b≠0: latch |a|, |b| (unsigned ops use raw values) and the signs; clear the counter; → DIV.
  - valid with DIV/DIVU and b=0: result hi=a, lo=0xFFFFFFFF; → DONE.
  - MTHI: `mdu_hi_o`=a, whien=1, combinational, no stall. MTLO: `mdu_lo_o`=a, wloen=1, same rules.
- **MUL**
  - Registers the 64-bit product: signed for MULT, unsigned for MULTU. hi=prod[63:32], lo=prod[31:0].
  - → DONE.
- **DIV**
  - One radix-2 restoring step per cycle on a 64-bit partial-remainder/quotient register.
  - The counter increments each cycle. After the 32nd step → FIX.
- **FIX**
  - Signed ops negate the quotient when sign(a)≠sign(b), and negate the remainder when a<0.
  - hi=remainder, lo=quotient. → DONE.
- **DONE**
  - whien=wloen=1; hi/lo come from the result registers; stallreq=0.
  - Holds DONE while `mdu_stall_i`=1, with outputs stable. Otherwise → IDLE.
- `mdu_stallreq_o` = valid & op∈{MULT, MULTU, DIV, DIVU} & state≠DONE & !flush.
- In every state other than DONE, and apart from MTHI/MTLO in IDLE, whien=wloen=0. In those cases hi/lo are don't-care and are driven from the result registers.
- Flush in any state → IDLE next cycle. No write enable is asserted in the flush cycle.
- Signed 0x80000000 / −1 gives q=0x80000000, r=0. No trap.

## Timing
- Reset values: state=IDLE, result registers=0, counter=0. All outputs 0.
- MULT/MULTU issued at cycle T:
  - T in IDLE, T+1 in MUL, T+2 in DONE.
  - stallreq is high at T and T+1, low at T+2.
  - Write enables are high at T+2.
- DIV/DIVU issued at T:
  - DIV for T+1..T+32, FIX at T+33, DONE at T+34.
  - stallreq is high from T through T+33.
- Divide by zero: DONE at T+1.
- MTHI/MTLO: zero latency.
- An op arriving in the cycle after DONE starts fresh. Back-to-back DIVs are legal.
- Reset asserted mid-division aborts immediately. State returns to IDLE and outputs go to 0.

## Structure
- Add to `defines.v`:
  - `MDOP` width macro (2:0).
  - Op-code constants `MD_NOP` … `MD_MTLO`.
- Keep the FSM state encodings local to the block.
- One sub-module: `div_iter`, the 32-step restoring divider core.
  - Inputs: start, unsigned operands.
  - Outputs: quotient, remainder, done.
  - Flush input returns it to idle.
- Sign handling and the multiplier stay in `mdu`.

## Test plan
- MULT a=0xFFFFFFFE (−2), b=3 → at T+2: hi=0xFFFFFFFF, lo=0xFFFFFFFA, whien=wloen=1; stallreq high for exactly 2 cycles.
- DIV a=−7, b=2 → at T+34: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=0xFFFFFFFF, b=0x10 → lo=0x0FFFFFFF, hi=0xF.
- DIV a=5, b=0 → at T+1: hi=5, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0x12345678 → same cycle: hi_o=0x12345678, whien=1, wloen=0, stallreq=0.
- DIV in progress, flush at cycle 10 → next cycle IDLE, stallreq=0, no write enables; a following MULTU 0xFFFFFFFF×2 gives hi=1, lo=0xFFFFFFFE.
- `mdu_stall_i` held for 3 cycles at DONE → hi/lo/enables stable for 3 cycles, then IDLE. `rst_n` low mid-DIV → all outputs 0 immediately.
